// File: rtl/toggle_arbiter.sv
// Four-requester round-robin arbiter sharing one XOR toggle flip-flop.
// Optional 8-bit flip counter port is enabled by defining TOGGLE_ARB_CNT_EN.
module toggle_arbiter #(
   parameter logic INIT_OUT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] tin,
   output logic [3:0] gnt,
   output logic [3:0] done,
   output logic       out,
   output logic       busy
`ifdef TOGGLE_ARB_CNT_EN
   ,
   output logic [7:0] flip_cnt
`endif
);

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      APPLY = 2'b10
   } state_e;

   state_e             state_q;
   logic [N_REQ-1:0]   gnt_q;
   logic [N_REQ-1:0]   done_q;
   logic               out_q;
   logic               busy_q;
   logic               cap_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   winner_q;

   logic [N_REQ-1:0]   elig_c;
   logic               win_vld_c;
   logic [IDX_W-1:0]   win_idx_c;

   // Round-robin pick: scanned from the far end so the nearest offset to ptr wins.
   always_comb begin
      elig_c    = req & ~done_q;
      win_vld_c = 1'b0;
      win_idx_c = ptr_q;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (elig_c[ptr_q + IDX_W'(k)]) begin
            win_vld_c = 1'b1;
            win_idx_c = ptr_q + IDX_W'(k);
         end
      end
   end

`ifdef TOGGLE_ARB_CNT_EN
   logic [CNT_W-1:0] cnt_q;
`endif

   // Transaction FSM with all outputs registered; gnt/done default low so they pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         winner_q <= '0;
         cap_q    <= 1'b0;
         out_q    <= INIT_OUT;
`ifdef TOGGLE_ARB_CNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_vld_c) begin
                  winner_q <= win_idx_c;
                  gnt_q    <= N_REQ'(1) << win_idx_c;
                  busy_q   <= 1'b1;
                  state_q  <= GRANT;
               end else begin
                  busy_q   <= 1'b0;
               end
            end
            GRANT: begin
               cap_q   <= tin[winner_q];
               busy_q  <= 1'b1;
               state_q <= APPLY;
            end
            APPLY: begin
               out_q   <= out_q ^ cap_q;
               done_q  <= N_REQ'(1) << winner_q;
               ptr_q   <= winner_q + IDX_W'(1);
               busy_q  <= 1'b0;
               state_q <= IDLE;
`ifdef TOGGLE_ARB_CNT_EN
               if (cap_q) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign out  = out_q;
   assign busy = busy_q;
`ifdef TOGGLE_ARB_CNT_EN
   assign flip_cnt = cnt_q;
`endif

   // Structural invariants of the grant/done pulses.
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
   a_done_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
   a_gnt_done_excl : assert property (@(posedge clk) disable iff (rst) !((|gnt_q) && (|done_q)));

endmodule

// File: tb/tb_toggle_arbiter.sv
// Directed self-checking bench for toggle_arbiter (default INIT_OUT = 0).
module tb_toggle_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] tin;
   logic [3:0] gnt;
   logic [3:0] done;
   logic       out;
   logic       busy;
`ifdef TOGGLE_ARB_CNT_EN
   logic [7:0] flip_cnt;
`endif

   int total;
   int passed;
   int failed;

   toggle_arbiter #(.INIT_OUT(1'b0)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .tin  (tin),
      .gnt  (gnt),
      .done (done),
      .out  (out),
      .busy (busy)
`ifdef TOGGLE_ARB_CNT_EN
      ,
      .flip_cnt (flip_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      total  = 0;
      passed = 0;
      failed = 0;
      rst = 1'b1;
      req = 4'b0000;
      tin = 4'b0000;
      tick();
      tick();
      chk("rst_gnt", 8'(gnt), 8'h00);
      chk("rst_done", 8'(done), 8'h00);
      chk("rst_out", 8'(out), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
`ifdef TOGGLE_ARB_CNT_EN
      chk("rst_cnt", flip_cnt, 8'h00);
`endif
      rst = 1'b0;
      tick();

      // Single requester 0 with tin=1; req dropped after grant still completes.
      req = 4'b0001;
      tin = 4'b0001;
      tick();
      chk("b_gnt_n1", 8'(gnt), 8'h01);
      chk("b_busy_n1", 8'(busy), 8'h01);
      chk("b_out_n1", 8'(out), 8'h00);
      req = 4'b0000;
      tick();
      chk("b_gnt_n2", 8'(gnt), 8'h00);
      chk("b_done_n2", 8'(done), 8'h00);
      chk("b_busy_n2", 8'(busy), 8'h01);
      tick();
      chk("b_done_n3", 8'(done), 8'h01);
      chk("b_out_n3", 8'(out), 8'h01);
      chk("b_busy_n3", 8'(busy), 8'h00);
      chk("b_gnt_n3", 8'(gnt), 8'h00);
      tick();
      chk("b_done_n4", 8'(done), 8'h00);
      chk("b_gnt_n4", 8'(gnt), 8'h00);

      // Requester 2 with tin=0 (ptr=1); tin change during APPLY is ignored.
      req = 4'b0100;
      tin = 4'b0000;
      tick();
      chk("c_gnt", 8'(gnt), 8'h04);
      req = 4'b0000;
      tick();
      tin = 4'b1111;
      tick();
      chk("c_done", 8'(done), 8'h04);
      chk("c_out", 8'(out), 8'h01);
`ifdef TOGGLE_ARB_CNT_EN
      chk("c_cnt", flip_cnt, 8'h01);
`endif
      tin = 4'b0000;
      tick();

      // ptr=3 wraps to requester 0; held req is masked during its done cycle.
      req = 4'b0001;
      tin = 4'b0001;
      tick();
      chk("d_gnt", 8'(gnt), 8'h01);
      tick();
      tick();
      chk("d_done", 8'(done), 8'h01);
      chk("d_out", 8'(out), 8'h00);
      tick();
      chk("d_mask_gnt", 8'(gnt), 8'h00);
      chk("d_mask_busy", 8'(busy), 8'h00);
      tick();
      chk("d_regnt", 8'(gnt), 8'h01);
      tick();
      chk("d_apply_busy", 8'(busy), 8'h01);

      // Reset during APPLY aborts; req held high during reset is ignored.
      rst = 1'b1;
      req = 4'b1111;
      tin = 4'b1111;
      tick();
      chk("abort_done", 8'(done), 8'h00);
      chk("abort_out", 8'(out), 8'h00);
      chk("abort_busy", 8'(busy), 8'h00);
      chk("abort_gnt", 8'(gnt), 8'h00);
      tick();
      chk("rstprio_gnt", 8'(gnt), 8'h00);
      chk("rstprio_busy", 8'(busy), 8'h00);
      rst = 1'b0;

      // All four requesting from reset: grants 0,1,2,3,0 and out 1,0,1,0,1.
      for (int i = 0; i < 5; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (i % 4);
         tick();
         chk("rr_gnt", 8'(gnt), 8'(oh));
         tick();
         tick();
         chk("rr_done", 8'(done), 8'(oh));
         chk("rr_out", 8'(out), ((i % 2) == 0) ? 8'h01 : 8'h00);
      end
      req = 4'b0000;
      tin = 4'b0000;
      for (int i = 0; i < 4; i++) tick();
      chk("drain_busy", 8'(busy), 8'h00);

`ifdef TOGGLE_ARB_CNT_EN
      // 256 toggling transactions: counter wraps to 0 and out returns to INIT_OUT.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0001;
      tin = 4'b0001;
      for (int k = 0; k < 256; k++) begin
         tick();
         tick();
         tick();
         if (k == 0) chk("cnt_first", flip_cnt, 8'h01);
         if (k == 254) chk("cnt_255", flip_cnt, 8'hff);
         tick();
      end
      chk("cnt_wrap", flip_cnt, 8'h00);
      chk("cnt_out", 8'(out), 8'h00);
      req = 4'b0000;
      tin = 4'b0000;
      for (int i = 0; i < 4; i++) tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/toggle_arbiter.md
TOGGLE_ARBITER -- requirements
Module: toggle_arbiter

Interface
REQ-001 Parameter INIT_OUT, default 1'b0: value loaded into out on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester toggle request; bit i = requester i.
REQ-005 tin  input  4  per-requester toggle data; only bit of granted requester used.
REQ-006 gnt  output 4  one-hot grant, registered, high exactly one cycle per transaction.
REQ-007 done output 4  one-hot completion pulse, registered, high exactly one cycle.
REQ-008 out  output 1  shared XOR flip-flop state; out_next = out ^ captured tin bit.
REQ-009 busy output 1  high whenever FSM is not IDLE.

Function
REQ-010 FSM states IDLE, GRANT, APPLY; encoded in 2 bits; unused encoding SHALL return to IDLE next cycle.
REQ-011 IDLE: if (req & ~mask) != 0, select winner by round-robin starting at ptr, gnt <= onehot(winner), go GRANT; else stay IDLE.
REQ-012 mask = done from the same cycle; a requester is ineligible in the cycle its done is high.
REQ-013 GRANT: capture cap <= tin[winner]; gnt <= 0; go APPLY.
REQ-014 APPLY: out <= out ^ cap; done <= onehot(winner); ptr <= (winner+1) mod 4; go IDLE.
REQ-015 Latency: req sampled in cycle N (IDLE) -> gnt high N+1 -> out updated and done high N+3; next arbitration possible in N+3.
REQ-016 Round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); ptr resets to 0.
REQ-017 req/tin changes during GRANT/APPLY SHALL NOT abort or alter the transaction except tin[winner] sampled in GRANT.
REQ-018 req of the winner dropping after IDLE sampling SHALL still complete the transaction.
REQ-019 tin bit 0 captured -> transaction completes, done pulses, out unchanged.
REQ-020 At most one gnt bit and one done bit high in any cycle; gnt and done never high in the same cycle.

Reset
REQ-021 rst high at posedge: state <= IDLE, gnt <= 0, done <= 0, busy <= 0, ptr <= 0, cap <= 0, out <= INIT_OUT.
REQ-022 rst mid-transaction SHALL abort it: no done pulse, out not updated, reset values next cycle.
REQ-023 rst has priority over all other inputs.

Configuration
REQ-024 Macro TOGGLE_ARB_CNT_EN defined: adds output port flip_cnt [7:0], reset 0, incremented in APPLY only when cap == 1, wraps 255 -> 0.
REQ-025 Macro TOGGLE_ARB_CNT_EN undefined: flip_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-026 Reset, INIT_OUT=0, then req=4'b0001, tin=4'b0001 held -> gnt=0001 at N+1, out=1 and done=0001 at N+3.
REQ-027 req=4'b1111, tin=4'b1111 held from reset -> grants in order 0001,0010,0100,1000,0001, out toggles each transaction (1,0,1,0,1).
REQ-028 req=4'b0100, tin=0 -> done=0100 pulses, out stays at prior value, flip_cnt unchanged (CNT_EN).
REQ-029 rst asserted in cycle N+2 of a transaction with tin=1 -> no done pulse, out=INIT_OUT, busy=0 next cycle.
REQ-030 With TOGGLE_ARB_CNT_EN, 256 transactions with tin=1 -> flip_cnt wraps to 0, out back to INIT_OUT.
